// File: rtl/conv2d_pkg.sv
// conv2d_pkg
// Shared constants and width helpers for the streaming 3x3 convolution engine.
//   KERNEL_TAPS : number of kernel coefficients (3x3)
//   COEF_ADDR_W : width of the coefficient write address
//   prod_width  : signed product width (pixel zero-extended by one bit)
//   acc_width   : accumulator width (product width plus guard bits for 9 taps)
package conv2d_pkg;

  localparam int KERNEL_TAPS = 9;
  localparam int COEF_ADDR_W = 4;
  localparam int GUARD_BITS  = 4;

  function automatic int prod_width(input int pix_w, input int coef_w);
    return pix_w + coef_w + 1;
  endfunction

  function automatic int acc_width(input int pix_w, input int coef_w);
    return prod_width(pix_w, coef_w) + GUARD_BITS;
  endfunction

endpackage

// File: rtl/conv2d_stream3x3_line_buffer.sv
// conv2d_stream3x3_line_buffer
// One image line of storage: DEPTH x WIDTH, one write port and one registered
// read port. A read and a write in the same cycle to the same address return
// the old contents. Storage is not reset; its contents are don't-care.
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read enable; rd_data holds when low
//   rd_addr : read address
//   rd_data : registered read data
module conv2d_stream3x3_line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv2d_stream3x3.sv
// conv2d_stream3x3
// Streaming 3x3 convolution over a raster-order pixel stream. Two line buffers
// supply the two rows above the incoming pixel; a 3x2 history register holds
// the two previous columns of the window. Products are registered in S1, the
// sum is shifted and saturated/truncated into the output register in S2.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   coef_we    : coefficient write strobe (applied only while idle)
//   coef_addr  : coefficient index k = 3*row + col; 9..15 ignored
//   coef_data  : signed coefficient value
//   in_valid   : input pixel valid
//   in_ready   : engine can accept a pixel
//   in_pixel   : input pixel, unsigned
//   out_valid  : result valid
//   out_ready  : downstream accepts the result
//   out_pixel  : result pixel
//   out_last   : last result of the frame
//   busy       : frame in progress
//   frame_done : one-cycle pulse after the last result is accepted
module conv2d_stream3x3
  import conv2d_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int COEF_W    = 8,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 0,
  parameter int SAT_EN    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   coef_we,
  input  logic [COEF_ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0]      coef_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_pixel,
  output logic                   out_last,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int PROD_W = prod_width(PIX_W, COEF_W);
  localparam int ACC_W  = acc_width(PIX_W, COEF_W);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({OUT_W{1'b1}});

  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic advance, accept, at_last, win_ok, last_beat;
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic [PIX_W-1:0] win  [3][3];
  logic [PIX_W-1:0] hist [3][2];
  logic signed [COEF_W-1:0] coef    [KERNEL_TAPS];
  logic signed [PROD_W-1:0] prod    [KERNEL_TAPS];
  logic signed [PROD_W-1:0] s1_prod [KERNEL_TAPS];
  logic s1_valid, s1_last;
  logic signed [ACC_W-1:0] acc_sum, acc_shift;
  logic [OUT_W-1:0] res;

  // A held output beat freezes every stage, including input acceptance.
  assign advance   = !(out_valid && !out_ready);
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign at_last   = (row == ROW_LAST) && (col == COL_LAST);
  assign win_ok    = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign last_beat = out_valid && out_ready && out_last;

  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (accept) begin
      if (col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col_nxt = col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Reads are addressed with the next column so the registered read data
  // already holds the rows above the pixel that is about to arrive.
  conv2d_stream3x3_line_buffer #(
    .DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)
  ) u_lb0 (
    .clk(clk), .wr_en(accept), .wr_addr(col), .wr_data(in_pixel),
    .rd_en(advance), .rd_addr(col_nxt), .rd_data(lb0_q)
  );

  conv2d_stream3x3_line_buffer #(
    .DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)
  ) u_lb1 (
    .clk(clk), .wr_en(accept), .wr_addr(col), .wr_data(lb0_q),
    .rd_en(advance), .rd_addr(col_nxt), .rd_data(lb1_q)
  );

  // Window row 0 is the top (r-2), column 2 is the incoming column c.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win[i][0] = hist[i][0];
      win[i][1] = hist[i][1];
    end
    win[0][2] = lb1_q;
    win[1][2] = lb0_q;
    win[2][2] = in_pixel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        hist[i][0] <= '0;
        hist[i][1] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        hist[i][0] <= hist[i][1];
        hist[i][1] <= win[i][2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < KERNEL_TAPS; k++) coef[k] <= '0;
      coef[KERNEL_TAPS / 2] <= COEF_W'(1);
    end else if (coef_we && !busy && !s1_valid && !out_valid &&
                 (coef_addr < COEF_ADDR_W'(KERNEL_TAPS))) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_comb begin
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      prod[k] = $signed({{(PROD_W - PIX_W){1'b0}}, win[k / 3][k % 3]}) *
                $signed({{(PROD_W - COEF_W){coef[k][COEF_W-1]}}, coef[k]});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int k = 0; k < KERNEL_TAPS; k++) s1_prod[k] <= '0;
    end else if (advance) begin
      s1_valid <= accept && win_ok;
      s1_last  <= accept && at_last;
      if (accept) s1_prod <= prod;
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < KERNEL_TAPS; k++) acc_sum = acc_sum + ACC_W'(s1_prod[k]);
    acc_shift = acc_sum >>> OUT_SHIFT;
    res = acc_shift[OUT_W-1:0];
    if (SAT_EN != 0) begin
      if (acc_shift[ACC_W-1])       res = '0;
      else if (acc_shift > SAT_MAX) res = '1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) out_pixel <= res;
    end
  end

  // When the last beat leaves, stay busy only if the next frame has already
  // begun (counters moved off the origin).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_beat;
      if (accept)         busy <= 1'b1;
      else if (last_beat) busy <= (col != '0) || (row != '0);
    end
  end

endmodule
